// File: rtl/multi_port_free_list_pkg.sv
// Shared sizing for the rename free list and the branch checkpoint table.
// fl_ptr_t is the head-pointer snapshot format both blocks exchange.
package multi_port_free_list_pkg;
    localparam int FREE_LIST_DEPTH       = 32;
    localparam int FREE_LIST_PTR_WIDTH   = $clog2(FREE_LIST_DEPTH) + 1;
    localparam int FREE_LIST_ALLOC_PORTS = 2;
    localparam int FREE_LIST_FREE_PORTS  = 2;
    localparam int FREE_LIST_TAG_WIDTH   = 6;
    localparam int FREE_LIST_INIT_BASE   = 32;

    typedef logic [FREE_LIST_PTR_WIDTH-1:0] fl_ptr_t;
endpackage

// File: rtl/multi_port_free_list_lane_rank.sv
// Exclusive prefix popcount: rank of lane i = number of set bits below i.
// Also reports the total number of set bits.
module lane_rank #(
    parameter int LANES = 2,
    parameter int RW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]    vec,
    output logic [LANES*RW-1:0] rank,
    output logic [RW-1:0]       total
);
    always_comb begin
        rank  = '0;
        total = '0;
        for (int i = 0; i < LANES; i++) begin
            rank[i*RW +: RW] = total;
            total            = total + RW'(vec[i]);
        end
    end
endmodule

// File: rtl/multi_port_free_list.sv
// Multi-lane physical-register free list: circular tag array with wrap-bit
// head/tail pointers, all-or-nothing allocation and single-cycle head restore.
module multi_port_free_list
    import multi_port_free_list_pkg::*;
#(
    parameter int TAG_WIDTH   = FREE_LIST_TAG_WIDTH,
    parameter int DEPTH       = FREE_LIST_DEPTH,
    parameter int ALLOC_PORTS = FREE_LIST_ALLOC_PORTS,
    parameter int FREE_PORTS  = FREE_LIST_FREE_PORTS,
    parameter int INIT_BASE   = FREE_LIST_INIT_BASE,
    parameter int PTR_W       = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ALLOC_PORTS-1:0]         alloc_req,
    output logic                           alloc_ok,
    output logic [ALLOC_PORTS*TAG_WIDTH-1:0] alloc_tag,
    input  logic [FREE_PORTS-1:0]          free_valid,
    input  logic [FREE_PORTS*TAG_WIDTH-1:0] free_tag,
    input  logic                           restore,
    input  logic [PTR_W-1:0]               restore_ptr,
    output logic [PTR_W-1:0]               head_ptr,
    output logic [PTR_W-1:0]               count,
    output logic                           empty,
    output logic                           full,
    output logic                           overflow_err
);
    localparam int IDX_W = PTR_W - 1;
    localparam int ARW   = $clog2(ALLOC_PORTS + 1);
    localparam int FRW   = $clog2(FREE_PORTS + 1);

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [TAG_WIDTH-1:0] mem_q [DEPTH];
    logic [TAG_WIDTH-1:0] mem_d [DEPTH];
    logic                 ovf_q, ovf_d;

    logic [ALLOC_PORTS*ARW-1:0] alloc_rank;
    logic [ARW-1:0]             alloc_n;
    logic [FREE_PORTS-1:0]      free_acc;
    logic [FREE_PORTS*FRW-1:0]  free_rank;
    logic [FRW-1:0]             free_k;
    logic [PTR_W-1:0]           space;

    lane_rank #(.LANES(ALLOC_PORTS), .RW(ARW)) u_alloc_rank (
        .vec   (alloc_req),
        .rank  (alloc_rank),
        .total (alloc_n)
    );

    lane_rank #(.LANES(FREE_PORTS), .RW(FRW)) u_free_rank (
        .vec   (free_acc),
        .rank  (free_rank),
        .total (free_k)
    );

    assign count        = tail_q - head_q;
    assign head_ptr     = head_q;
    assign empty        = (count == '0);
    assign full         = (count == PTR_W'(DEPTH));
    assign overflow_err = ovf_q;
    assign space        = PTR_W'(DEPTH) - count;

    // Allocation handshake: the requested lanes are granted together when
    // alloc_ok is high in that cycle; with alloc_ok low nothing is consumed.
    assign alloc_ok = (PTR_W'(alloc_n) <= count) && !restore;

    always_comb begin : alloc_read
        logic [PTR_W-1:0] p;
        alloc_tag = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            p = head_q + PTR_W'(alloc_rank[i*ARW +: ARW]);
            alloc_tag[i*TAG_WIDTH +: TAG_WIDTH] = mem_q[p[IDX_W-1:0]];
        end
    end

    always_comb begin
        for (int j = 0; j < FREE_PORTS; j++) begin
            free_acc[j] = free_valid[j] && (free_tag[j*TAG_WIDTH +: TAG_WIDTH] != '0);
        end
    end

    always_comb begin : next_state
        logic [PTR_W-1:0] r;
        logic [PTR_W-1:0] p;
        mem_d  = mem_q;
        ovf_d  = ovf_q;
        tail_d = tail_q;
        head_d = head_q;
        r      = '0;
        p      = '0;

        // Releases beyond the free space are dropped, not wrapped over live slots.
        if (PTR_W'(free_k) > space) begin
            tail_d = tail_q + space;
            ovf_d  = 1'b1;
        end else begin
            tail_d = tail_q + PTR_W'(free_k);
        end

        for (int j = 0; j < FREE_PORTS; j++) begin
            r = PTR_W'(free_rank[j*FRW +: FRW]);
            if (free_acc[j] && (r < space)) begin
                p = tail_q + r;
                mem_d[p[IDX_W-1:0]] = free_tag[j*TAG_WIDTH +: TAG_WIDTH];
            end
        end

        if (restore) begin
            head_d = restore_ptr;
        end else if (alloc_ok) begin
            head_d = head_q + PTR_W'(alloc_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= PTR_W'(DEPTH);
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_WIDTH'(INIT_BASE + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: tb/tb_multi_port_free_list.sv
// Bench for multi_port_free_list: directed scenarios then random traffic,
// checked against a pointer-and-array reference model through a scoreboard.
module tb_multi_port_free_list;
    localparam int TW = 6;
    localparam int PW = 6;
    localparam int D  = 32;
    localparam int EW = 30;

    logic            clk;
    logic            rst;
    logic [1:0]      alloc_req;
    logic            alloc_ok;
    logic [2*TW-1:0] alloc_tag;
    logic [1:0]      free_valid;
    logic [2*TW-1:0] free_tag;
    logic            restore;
    logic [PW-1:0]   restore_ptr;
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   count;
    logic            empty;
    logic            full;
    logic            overflow_err;

    multi_port_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_ok     (alloc_ok),
        .alloc_tag    (alloc_tag),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .restore      (restore),
        .restore_ptr  (restore_ptr),
        .head_ptr     (head_ptr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow_err (overflow_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: absolute (unbounded) head/tail counts plus slot array
    int          m_head;
    int          m_tail;
    logic [TW-1:0] m_mem [D];
    bit          m_ovf;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [TW-1:0] owned_q[$];

    task automatic model_reset();
        m_head = 0;
        m_tail = D;
        m_ovf  = 1'b0;
        for (int i = 0; i < D; i++) m_mem[i] = TW'(32 + i);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // driver: apply one cycle of stimulus, queue the expectation, advance model
    task automatic cycle(input logic [1:0] req, input logic [1:0] fv,
                         input logic [TW-1:0] ft0, input logic [TW-1:0] ft1,
                         input logic rs, input logic [PW-1:0] rp, input string nm,
                         output logic g_ok, output logic [TW-1:0] g_t0, output logic [TW-1:0] g_t1);
        int cnt, n, rk, space, wr, d;
        logic [TW-1:0] t [2];
        logic [TW-1:0] ft [2];
        alloc_req   = req;
        free_valid  = fv;
        free_tag    = {ft1, ft0};
        restore     = rs;
        restore_ptr = rp;
        ft[0] = ft0;
        ft[1] = ft1;
        cnt  = m_tail - m_head;
        n    = int'(req[0]) + int'(req[1]);
        g_ok = !rs && (n <= cnt);
        rk   = 0;
        for (int i = 0; i < 2; i++) begin
            t[i] = m_mem[(m_head + rk) % D];
            if (req[i]) rk++;
        end
        g_t0 = t[0];
        g_t1 = t[1];
        exp_q.push_back({req, g_ok, t[1], t[0], PW'(cnt), PW'(m_head % 64),
                         cnt == D, cnt == 0, m_ovf});
        name_q.push_back(nm);

        space = D - cnt;
        wr    = 0;
        for (int j = 0; j < 2; j++) begin
            if (fv[j] && ft[j] != 0) begin
                if (wr < space) begin
                    m_mem[(m_tail + wr) % D] = ft[j];
                    wr++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_tail += wr;
        if (rs) begin
            d = ((m_head % 64) - int'(rp) + 64) % 64;
            m_head -= d;
        end else if (g_ok) begin
            m_head += n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] req, input logic rs);
        alloc_req   = req;
        restore     = rs;
        restore_ptr = 6'd17;
        free_valid  = 2'b11;
        free_tag    = {6'd9, 6'd10};
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        alloc_req   = '0;
        restore     = 1'b0;
        free_valid  = '0;
        free_tag    = '0;
        model_reset();
    endtask

    // scoreboard monitor: compare DUT outputs with the queued expectation
    always @(negedge clk) begin
        logic [EW-1:0] e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, " alloc_ok"}, 32'(alloc_ok), 32'(e[27]));
            if (e[27] && e[28]) check({nm, " tag0"}, 32'(alloc_tag[TW-1:0]), 32'(e[20:15]));
            if (e[27] && e[29]) check({nm, " tag1"}, 32'(alloc_tag[2*TW-1:TW]), 32'(e[26:21]));
            check({nm, " count"}, 32'(count), 32'(e[14:9]));
            check({nm, " head_ptr"}, 32'(head_ptr), 32'(e[8:3]));
            check({nm, " full/empty/ovf"}, 32'({full, empty, overflow_err}), 32'(e[2:0]));
        end
    end

    initial begin
        logic ok;
        logic [TW-1:0] t0, t1;
        logic [1:0] req, fv;
        logic [TW-1:0] ft0, ft1;
        int idx;

        rst = 1'b1; alloc_req = '0; free_valid = '0; free_tag = '0;
        restore = 1'b0; restore_ptr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        cycle(2'b00, 2'b00, 0, 0, 0, 0, "reset_state", ok, t0, t1);
        cycle(2'b00, 2'b01, 6'd7, 0, 0, 0, "release_into_full", ok, t0, t1);
        repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0, "ovf_sticky", ok, t0, t1);
        cycle(2'b11, 2'b00, 0, 0, 0, 0, "ovf_sticky_alloc", ok, t0, t1);
        do_reset(2'b11, 1'b1);
        cycle(2'b00, 2'b00, 0, 0, 0, 0, "reset_mid_alloc_restore", ok, t0, t1);

        cycle(2'b11, 2'b00, 0, 0, 0, 0, "first_alloc", ok, t0, t1);
        cycle(2'b00, 2'b00, 0, 0, 0, 0, "after_first_alloc", ok, t0, t1);
        cycle(2'b01, 2'b00, 0, 0, 0, 0, "pre_snapshot", ok, t0, t1);
        cycle(2'b00, 2'b00, 0, 0, 0, 0, "snapshot_head3", ok, t0, t1);
        cycle(2'b11, 2'b00, 0, 0, 0, 0, "alloc_a", ok, t0, t1);
        cycle(2'b11, 2'b00, 0, 0, 0, 0, "alloc_b", ok, t0, t1);
        cycle(2'b01, 2'b00, 0, 0, 1'b1, 6'd3, "restore_nogrant", ok, t0, t1);
        cycle(2'b11, 2'b00, 0, 0, 0, 0, "reissue_a", ok, t0, t1);
        cycle(2'b11, 2'b00, 0, 0, 0, 0, "reissue_b", ok, t0, t1);

        while (m_tail - m_head >= 2) cycle(2'b11, 2'b00, 0, 0, 0, 0, "drain", ok, t0, t1);
        cycle(2'b11, 2'b00, 0, 0, 0, 0, "count1_two_req", ok, t0, t1);
        cycle(2'b10, 2'b00, 0, 0, 0, 0, "count1_lane1", ok, t0, t1);
        cycle(2'b01, 2'b11, 6'd5, 6'd0, 0, 0, "empty_release_5_0", ok, t0, t1);
        cycle(2'b01, 2'b00, 0, 0, 0, 0, "alloc_released_5", ok, t0, t1);
        cycle(2'b00, 2'b00, 0, 0, 0, 0, "empty_again", ok, t0, t1);

        do_reset(2'b00, 1'b0);
        for (int c = 0; c < 3 * D + 104; c++) begin
            req = 2'($urandom_range(0, 3));
            fv  = '0;
            ft0 = '0;
            ft1 = '0;
            if (owned_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, owned_q.size() - 1);
                fv[0] = 1'b1; ft0 = owned_q[idx]; owned_q.delete(idx);
            end else if ($urandom_range(0, 3) == 0) begin
                fv[0] = 1'b1;
            end
            if (owned_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, owned_q.size() - 1);
                fv[1] = 1'b1; ft1 = owned_q[idx]; owned_q.delete(idx);
            end
            cycle(req, fv, ft0, ft1, 0, 0, "random", ok, t0, t1);
            if (ok && req[0]) owned_q.push_back(t0);
            if (ok && req[1]) owned_q.push_back(t1);
        end
        cycle(2'b00, 2'b00, 0, 0, 0, 0, "random_end", ok, t0, t1);
        check("conservation", 32'(count) + 32'(owned_q.size()), 32'(D));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_port_free_list.md
# multi_port_free_list

Parametrised physical-register free list for a superscalar rename stage. Up to ALLOC_PORTS tags are handed out and up to FREE_PORTS tags are returned per cycle. The read (head) pointer can be checkpointed and restored in one cycle on branch mispredict. It sits between rename (allocate), ROB commit (release) and the branch checkpoint table (head snapshot/restore).

## Interface
- TAG_WIDTH, 6: physical tag width.
- DEPTH, 32: entry count; power of two, ≥ 2·max(ALLOC_PORTS, FREE_PORTS).
- ALLOC_PORTS, 2: allocate lanes.
- FREE_PORTS, 2: release lanes.
- INIT_BASE, 32: reset contents are INIT_BASE+i for entry i.
- PTR_W, $clog2(DEPTH)+1: pointer width; MSB is the wrap bit.

Ports:
- clk  in  1  clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- alloc_req  in  ALLOC_PORTS  per-lane allocate request; any bit pattern is legal.
- alloc_ok  out  1  all requested lanes granted this cycle.
- alloc_tag  out  ALLOC_PORTS×TAG_WIDTH  tag for each requesting lane; 'x when that lane is not requesting or alloc_ok=0.
- free_valid  in  FREE_PORTS  per-lane release.
- free_tag  in  FREE_PORTS×TAG_WIDTH  tag to release.
- restore  in  1  mispredict recovery.
- restore_ptr  in  PTR_W  checkpointed head.
- head_ptr  out  PTR_W  current head, for checkpointing.
- count  out  PTR_W  free entries = tail − head.
- empty, full  out  1  count==0 / count==DEPTH.
- overflow_err  out  1  sticky: a release was dropped because the list was full.

## Operation
- Storage: DEPTH×TAG_WIDTH circular array with head and tail pointers of width PTR_W.
- Allocate: n = popcount(alloc_req). alloc_ok = (n ≤ count) && !restore. This is all-or-nothing: a partial grant never happens.
- Allocate lane i receives mem[(head + rank_i) mod DEPTH], where rank_i is the number of requesting lanes below i.
- On alloc_ok, head advances by n at the next edge.
- Release: lane j is accepted when free_valid[j] && free_tag[j]≠0. Tag 0 is dropped silently and not counted.
- Accepted lanes are written, compacted in lane order, to mem[(tail + rank_j) mod DEPTH]. Tail advances by the accepted count k.
- If k > DEPTH − count (using count before this cycle's allocation), only the first (DEPTH − count) accepted lanes are written. The rest are dropped and overflow_err is set. overflow_err clears only on rst.
- Restore: head ← restore_ptr. Allocation is suppressed that cycle. Releases still proceed normally.
- Simultaneous allocate and release: allocation sees the pre-release count; there is no same-cycle bypass. Releases and allocations never touch the same slot in one cycle.

## Timing
- alloc_ok and alloc_tag are combinational from alloc_req, restore and registered state, with zero-cycle latency. Pointer and memory updates occur at posedge clk.
- A released tag is allocatable from the cycle after its release.
- restore_ptr is effective on the cycle after restore. head_ptr, count and empty reflect the restored value then.
- Reset, synchronous and dominant over all other inputs, including mid-restore or mid-allocate:
  - head=0, tail=DEPTH (wrap bit 1, index 0), mem[i]=INIT_BASE+i.
  - overflow_err=0.
- Outputs in the cycle after reset: count=DEPTH, full=1, empty=0, head_ptr=0, alloc_ok=1 when n ≤ DEPTH.
- Wrap-around: index = pointer[PTR_W−2:0]. Pointer arithmetic is modulo 2^PTR_W. count = tail − head in PTR_W bits.

## Structure
- The params package holds FREE_LIST_DEPTH, FREE_LIST_PTR_WIDTH, the ALLOC/FREE lane counts, and a fl_ptr_t typedef. The branch checkpoint table shares fl_ptr_t.
- One sub-module, lane_rank: a parametrised exclusive-prefix popcount (vector in → per-lane rank and total). It is instantiated twice, once for allocate and once for release.

## Test plan
- Reset, then alloc_req=2'b11 → alloc_ok=1, tags 32 and 33. Next cycle count=30 and head_ptr=2.
- alloc_req=2'b10 with count=1 → lane 1 gets the head entry. alloc_req=2'b11 with count=1 → alloc_ok=0 and the pointers are unchanged.
- Drain to empty. In the same cycle, release tags 5 and 0 while requesting one allocation → alloc_ok=0, 0 dropped, count=1 next cycle, and the next allocate returns 5.
- From a full list, release tag 7 → dropped, overflow_err=1, and it stays 1 until rst.
- Snapshot head_ptr=3, allocate 4 over two cycles, then assert restore with restore_ptr=3 together with alloc_req=2'b01 → no grant. The next cycle head_ptr=3 and the same tags are re-issued.
- Run 3×DEPTH cycles of random alloc/release that preserve conservation → no tag is ever duplicated or lost, count equals the model, and the wrap bit toggles correctly.
